// File: rtl/axum_uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the transmit arbiter FSM state enum and the counter width.
package axum_uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } uart_arb_state_e;

  localparam int UART_DBIT  = 8;
  localparam int UART_CNT_W = 8;

endpackage

// File: rtl/axum_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first
// requester found at or after the pointer, wrapping modulo N.
module axum_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW:0] idx;
  logic        found;

  // scan from the pointer, first valid request wins
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_i} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req_i[idx[PW-1:0]]) begin
        gnt_o[idx[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axum_uart_tx_arb.sv
// Message-locked round-robin arbiter in front of the UART TX FIFO.
// Define AXUM_UART_ARB_PRIO_EN to give requester 0 priority in IDLE.
module axum_uart_tx_arb
  import axum_uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DBIT         = UART_DBIT,
  parameter int MAX_BURST    = 64,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*DBIT-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]      req_last_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic                    tx_full_i,
  output logic                    wr_uart_o,
  output logic [DBIT-1:0]         w_data_o,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = UART_CNT_W;
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);
  localparam logic [CW-1:0] TMO_LIM   = CW'(HOLD_TIMEOUT);

  uart_arb_state_e     state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       burst_q, burst_d;
  logic [CW-1:0]       idle_q, idle_d;
  logic                wr_q, wr_d;
  logic [DBIT-1:0]     wdata_q, wdata_d;

  logic [NUM_REQ-1:0]  rr_gnt, win;
  logic [DBIT-1:0]     hold_data;
  logic [PW-1:0]       hold_idx, rr_next;
  logic [CW-1:0]       burst_inc, idle_inc;
  logic                hold_valid, hold_last;
  logic                xfer, tmo, rel;

  axum_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_q),
    .gnt_o (rr_gnt)
  );

`ifdef AXUM_UART_ARB_PRIO_EN
  assign win = req_valid_i[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : rr_gnt;
`else
  assign win = rr_gnt;
`endif

  // select the current holder's byte and index
  always_comb begin
    hold_data = '0;
    hold_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        hold_data = hold_data | req_data_i[i*DBIT +: DBIT];
        hold_idx  = PW'(i);
      end
    end
  end

  assign hold_valid = |(req_valid_i & grant_q);
  assign hold_last  = |(req_last_i & grant_q);
  assign rr_next    = (hold_idx == PW'(NUM_REQ-1)) ? '0 : hold_idx + 1'b1;
  assign burst_inc  = burst_q + 1'b1;
  assign idle_inc   = idle_q + 1'b1;

  // one byte per two cycles: the write strobe blocks the next accept
  assign xfer = (state_q == LOCK) & hold_valid & ~tx_full_i & ~wr_q;
  assign tmo  = (state_q == LOCK) & ~hold_valid & (idle_inc == TMO_LIM);
  assign rel  = (xfer & (hold_last | (burst_inc == BURST_LIM))) | tmo;

  // next-state: arbitration, acceptance, counters and release
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d = LOCK;
          grant_d = win;
        end
      end
      LOCK: begin
        if (xfer) begin
          wr_d    = 1'b1;
          wdata_d = hold_data;
          burst_d = burst_inc;
          idle_d  = '0;
        end else if (!hold_valid) begin
          idle_d = idle_inc;
        end
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          burst_d = '0;
          idle_d  = '0;
          rr_d    = rr_next;
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready_o = grant_q & {NUM_REQ{~tx_full_i & ~wr_q}};
  assign wr_uart_o   = wr_q;
  assign w_data_o    = wdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == LOCK);

endmodule

// File: tb/tb_axum_uart_tx_arb.sv
// Scoreboard bench for axum_uart_tx_arb.
// Builds with MAX_BURST=4 and HOLD_TIMEOUT=8.
module tb_axum_uart_tx_arb;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int MB = 4;
  localparam int HT = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [N*DB-1:0] req_data_i;
  logic [N-1:0]  req_last_i;
  logic [N-1:0]  req_ready_o;
  logic          tx_full_i;
  logic          wr_uart_o;
  logic [DB-1:0] w_data_o;
  logic [N-1:0]  grant_o;
  logic          busy_o;

  axum_uart_tx_arb #(
    .NUM_REQ      (N),
    .DBIT         (DB),
    .MAX_BURST    (MB),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_full_i   (tx_full_i),
    .wr_uart_o   (wr_uart_o),
    .w_data_o    (w_data_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  logic [8:0]   mq [N][$];
  logic [7:0]   exp_q[$];
  logic [N-1:0] glog[$];
  int           wr_t[$];
  int checks, fails, cyc_n, idle_cnt, rel_cnt, nwr;
  logic         prev_busy;
  logic [N-1:0] prev_g;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0) begin
        req_valid_i[i]         = 1'b1;
        req_data_i[i*DB +: DB] = mq[i][0][7:0];
        req_last_i[i]          = mq[i][0][8];
      end else begin
        req_valid_i[i]         = 1'b0;
        req_data_i[i*DB +: DB] = '0;
        req_last_i[i]          = 1'b0;
      end
    end
  endtask

  task automatic msg(input int r, input logic [7:0] b0, input int n,
                     input bit lst, input int nexp);
    for (int k = 0; k < n; k++) begin
      mq[r].push_back({(lst && k == n-1), 8'(b0 + k)});
      if (k < nexp) exp_q.push_back(8'(b0 + k));
    end
  endtask

  task automatic cyc();
    logic [N-1:0] acc;
    @(negedge clk_i);
    cyc_n++;
    if (wr_uart_o) begin
      nwr++;
      wr_t.push_back(cyc_n);
      if (exp_q.size() == 0) chk("unexpected_wr", 32'(wr_uart_o), 0);
      else chk("wdata", 32'(w_data_o), 32'(exp_q.pop_front()));
    end
    if (busy_o && grant_o != prev_g) glog.push_back(grant_o);
    if (prev_busy && !busy_o) rel_cnt++;
    if (busy_o && ((grant_o & ~req_valid_i) != '0)) idle_cnt++;
    prev_busy = busy_o;
    prev_g    = grant_o;
    acc = req_ready_o & req_valid_i;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) void'(mq[i].pop_front());
    drive();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || busy_o) && k < budget) begin
      cyc();
      k++;
    end
    if (k >= budget) chk({tag, "_budget"}, 32'(k), 0);
  endtask

  initial begin
    int k;
    int nw0;
    checks = 0; fails = 0; cyc_n = 0; nwr = 0;
    idle_cnt = 0; rel_cnt = 0;
    prev_busy = 1'b0; prev_g = '0;
    rst_ni = 1'b0;
    tx_full_i = 1'b0;
    drive();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_wr",    32'(wr_uart_o), 0);
    chk("rst_wdata", 32'(w_data_o), 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // single requester, 3-byte message
    glog.delete(); wr_t.delete();
    msg(2, 8'h41, 3, 1'b1, 3);
    drive();
    wait_done("t1", 60);
    cyc();
    chk("t1_ngrant", 32'(glog.size()), 1);
    if (glog.size() > 0) chk("t1_grant", 32'(glog[0]), 32'h4);
    chk("t1_nwr", 32'(wr_t.size()), 3);
    if (wr_t.size() == 3) begin
      chk("t1_gap0", 32'(wr_t[1] - wr_t[0]), 2);
      chk("t1_gap1", 32'(wr_t[2] - wr_t[1]), 2);
    end
    chk("t1_grant_end", 32'(grant_o), 0);

    // two 4-byte messages offered in the same cycle
    glog.delete();
    msg(0, 8'hA0, 4, 1'b1, 4);
    msg(1, 8'hB0, 4, 1'b1, 4);
    drive();
    wait_done("t2", 80);
    cyc();
    chk("t2_ngrant", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t2_first", 32'(glog[0]), 32'h1);
      chk("t2_second", 32'(glog[1]), 32'h2);
    end

    // backpressure longer than the hold timeout
    glog.delete();
    msg(3, 8'hC0, 3, 1'b1, 3);
    drive();
    k = 0;
    while (exp_q.size() > 2 && k < 40) begin cyc(); k++; end
    if (k >= 40) chk("t3_budget", 32'(k), 0);
    tx_full_i = 1'b1;
    nw0 = nwr;
    k = rel_cnt;
    repeat (20) cyc();
    chk("t3_no_wr", 32'(nwr - nw0), 0);
    chk("t3_no_rel", 32'(rel_cnt - k), 0);
    chk("t3_busy", 32'(busy_o), 1);
    chk("t3_grant", 32'(grant_o), 32'h8);
    tx_full_i = 1'b0;
    wait_done("t3", 60);
    chk("t3_resume", 32'(nwr - nw0), 2);

    // 6-byte message split by the burst limit
    glog.delete();
    k = rel_cnt;
    msg(1, 8'hD0, 6, 1'b1, 6);
    drive();
    wait_done("t4", 80);
    cyc();
    chk("t4_releases", 32'(rel_cnt - k), 2);
    chk("t4_ngrant", 32'(glog.size()), 2);
    if (glog.size() == 2) chk("t4_regrant", 32'(glog[1]), 32'h2);

    // holder goes quiet, waiting requester takes over on timeout
    glog.delete();
    idle_cnt = 0;
    msg(2, 8'hE0, 1, 1'b0, 1);
    msg(3, 8'hF0, 1, 1'b1, 1);
    drive();
    wait_done("t5", 80);
    chk("t5_idle_cycles", 32'(idle_cnt), HT);
    chk("t5_ngrant", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t5_holder", 32'(glog[0]), 32'h4);
      chk("t5_next", 32'(glog[1]), 32'h8);
    end
    msg(2, 8'hE1, 1, 1'b1, 1);
    drive();
    wait_done("t5b", 60);

    // bring the pointer to 2, then contend 0 against 2
    msg(1, 8'h31, 1, 1'b1, 1);
    drive();
    wait_done("t6a", 60);
    glog.delete();
`ifdef AXUM_UART_ARB_PRIO_EN
    msg(0, 8'h50, 1, 1'b1, 1);
    msg(2, 8'h52, 1, 1'b1, 1);
`else
    msg(2, 8'h52, 1, 1'b1, 1);
    msg(0, 8'h50, 1, 1'b1, 1);
    exp_q.delete();
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h50);
`endif
    drive();
    wait_done("t6", 60);
    if (glog.size() > 0) begin
`ifdef AXUM_UART_ARB_PRIO_EN
      chk("t6_prio", 32'(glog[0]), 32'h1);
`else
      chk("t6_rr", 32'(glog[0]), 32'h4);
`endif
    end else begin
      chk("t6_ngrant", 32'(glog.size()), 2);
    end

    // reset after byte 2 of a 5-byte message
    msg(3, 8'h60, 5, 1'b1, 2);
    drive();
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin cyc(); k++; end
    if (k >= 40) chk("t7_budget", 32'(k), 0);
    chk("t7_busy_pre", 32'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("t7_ready", 32'(req_ready_o), 0);
    chk("t7_wr",    32'(wr_uart_o), 0);
    chk("t7_wdata", 32'(w_data_o), 0);
    chk("t7_grant", 32'(grant_o), 0);
    chk("t7_busy",  32'(busy_o), 0);
    mq[3].delete();
    drive();
    prev_busy = 1'b0; prev_g = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (4) cyc();
    chk("t7_grant_idle", 32'(grant_o), 0);
    glog.delete();
    msg(1, 8'h70, 1, 1'b1, 1);
    drive();
    wait_done("t7", 40);
    chk("t7_ngrant", 32'(glog.size()), 1);
    if (glog.size() > 0) chk("t7_new", 32'(glog[0]), 32'h2);

    repeat (3) cyc();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
